reset_sequencer: RTL and testbench

- Consumes the simulation/configuration global reset phase and the board-level reset sources (clock-manager lock, reset pushbutton). Produces the staged synchronous resets for the rest of the VGA design.
- The core (CPU/bus) leaves reset first. The video timing/pixel pipeline follows STAGGER cycles later, so the framebuffer path never starts against an unreset bus.
- Emits a one-cycle ready pulse when both domains are running.

---
 rtl/reset_sequencer_pkg.sv | 15 +
 rtl/reset_sequencer_sync_ff.sv | 23 ++
 rtl/reset_sequencer.sv | 129 ++++++++++++
 tb/tb_reset_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared types and defaults for the staged reset sequencer.
package reset_sequencer_pkg;

  localparam int unsigned HOLD_CYCLES_DEF = 16;
  localparam int unsigned STAGGER_DEF     = 4;

  typedef enum logic [2:0] {
    ST_HOLD  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_COUNT = 3'd2,
    ST_CORE  = 3'd3,
    ST_RUN   = 3'd4
  } state_t;

endpackage

// File: rtl/reset_sequencer_sync_ff.sv
// Two-flop synchronizer for an asynchronous level, with a selectable reset value.
module reset_sequencer_sync_ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset generator: core leaves reset after a stable hold, video follows STAGGER cycles later.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int unsigned STAGGER       = STAGGER_DEF,
  parameter int unsigned DEBOUNCE_BITS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic locked,
  input  logic btn_n,
  output logic rst_core,
  output logic rst_video,
  output logic ready
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic                     locked_s;
  logic                     btn_s;
  logic                     btn_deb;
  logic [DEBOUNCE_BITS-1:0] deb_cnt;
  logic                     fault;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          rst_core_nxt, rst_video_nxt, ready_nxt;

  reset_sequencer_sync_ff #(.RST_VAL(1'b0)) u_sync_locked (
    .clk (clk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  reset_sequencer_sync_ff #(.RST_VAL(1'b1)) u_sync_btn (
    .clk (clk),
    .rst (rst),
    .d   (btn_n),
    .q   (btn_s)
  );

  // Accept a new button level only after it differs for 2^DEBOUNCE_BITS consecutive edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_deb <= 1'b1;
      deb_cnt <= '0;
    end else if (btn_s == btn_deb) begin
      deb_cnt <= '0;
    end else if (&deb_cnt) begin
      btn_deb <= btn_s;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + DEBOUNCE_BITS'(1);
    end
  end

  assign fault = !locked_s || !btn_deb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_HOLD;
      cnt       <= '0;
      rst_core  <= 1'b1;
      rst_video <= 1'b1;
      ready     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rst_core  <= rst_core_nxt;
      rst_video <= rst_video_nxt;
      ready     <= ready_nxt;
    end
  end

  // Any fault drops back to WAIT, so a later release always sees the full hold count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready_nxt = 1'b0;
    case (state)
      ST_HOLD: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!fault) begin
          state_nxt = ST_COUNT;
          cnt_nxt   = '0;
        end
      end
      ST_COUNT: begin
        if (fault) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
        end else if (cnt == CW'(HOLD_CYCLES - 1)) begin
          state_nxt = ST_CORE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_CORE: begin
        if (fault) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
        end else if (cnt == CW'(STAGGER - 1)) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
          ready_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_RUN: begin
        if (fault) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_HOLD;
        cnt_nxt   = '0;
      end
    endcase
    rst_core_nxt  = !((state_nxt == ST_CORE) || (state_nxt == ST_RUN));
    rst_video_nxt = (state_nxt != ST_RUN);
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: streak-count model plus directed release-timing checks.
module tb_reset_sequencer;

  localparam int H  = 16;
  localparam int S  = 4;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst, locked, btn_n;
  logic rst_core, rst_video, ready;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  reset_sequencer #(
    .HOLD_CYCLES   (H),
    .STAGGER       (S),
    .DEBOUNCE_BITS (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .locked    (locked),
    .btn_n     (btn_n),
    .rst_core  (rst_core),
    .rst_video (rst_video),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  // Model: after the post-reset HOLD edge, count consecutive fault-free edges (g).
  // g==0 -> waiting, 1..H counting, H+1..H+S core out, beyond that run.
  int rel = 0;
  int g   = 0;
  int run_len = 0;
  bit hold_pend = 1'b1;
  bit l1, l2, b1, b2, deb, m_fault;

  always @(posedge clk) begin
    if (rst) begin
      l1 = 1'b0; l2 = 1'b0; b1 = 1'b1; b2 = 1'b1; deb = 1'b1;
      run_len = 0; g = 0; hold_pend = 1'b1; rel = 0;
    end else begin
      m_fault = !l2 || !deb;
      if (hold_pend) begin
        hold_pend = 1'b0;
        g = 0;
      end else if (m_fault) begin
        g = 0;
      end else if (g < H + S + 2) begin
        g = g + 1;
      end
      if (b2 != deb) begin
        run_len = run_len + 1;
        if (run_len == (1 << DB)) begin
          deb = b2;
          run_len = 0;
        end
      end else begin
        run_len = 0;
      end
      l2 = l1; l1 = locked;
      b2 = b1; b1 = btn_n;
      rel = rel + 1;
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at rel=%0d: got %b expected %b", name, rel, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model rst_core",  rst_core,  logic'(g <= H));
      check("model rst_video", rst_video, logic'(g <= H + S));
      check("model ready",     ready,     logic'(g == H + S + 1));
    end
  end

  task automatic wait_rel(input int n);
    int k = 0;
    while (rel != n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (rel != n) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_rel timeout: got rel=%0d expected %0d", rel, n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset rst_core",  rst_core,  1'b1);
    check("reset rst_video", rst_video, 1'b1);
    check("reset ready",     ready,     1'b0);
  endtask

  initial begin
    rst = 1'b1; locked = 1'b1; btn_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    check("s1 reset rst_core",  rst_core,  1'b1);
    check("s1 reset rst_video", rst_video, 1'b1);

    // Clean power-up: core at edge 19, video and ready at edge 23.
    wait_rel(18); check("s1 core held e18", rst_core, 1'b1);
    wait_rel(19); check("s1 core rel e19", rst_core, 1'b0);
                  check("s1 video held e19", rst_video, 1'b1);
    wait_rel(22); check("s1 video held e22", rst_video, 1'b1);
                  check("s1 no ready e22", ready, 1'b0);
    wait_rel(23); check("s1 video rel e23", rst_video, 1'b0);
                  check("s1 ready e23", ready, 1'b1);
    wait_rel(24); check("s1 ready gone e24", ready, 1'b0);

    // Short button glitch in RUN is absorbed; a long press reasserts both resets.
    wait_rel(30); btn_n = 1'b0;
    wait_rel(40); btn_n = 1'b1;
    wait_rel(60); check("s3 glitch core", rst_core, 1'b0);
                  check("s3 glitch video", rst_video, 1'b0);
    btn_n = 1'b0;
    wait_rel(78); check("s3 press core e18", rst_core, 1'b0);
    wait_rel(79); check("s3 press core e19", rst_core, 1'b1);
                  check("s3 press video e19", rst_video, 1'b1);
    wait_rel(100); btn_n = 1'b1;
    wait_rel(134); check("s3 release core held", rst_core, 1'b1);
    wait_rel(135); check("s3 release core", rst_core, 1'b0);
    wait_rel(139); check("s3 release video", rst_video, 1'b0);
                   check("s3 release ready", ready, 1'b1);

    // Clock manager unlocked for 50 cycles.
    locked = 1'b0;
    do_reset();
    wait_rel(50); locked = 1'b1;
    check("s2 core held unlocked", rst_core, 1'b1);
    wait_rel(68); check("s2 core held e68", rst_core, 1'b1);
    wait_rel(69); check("s2 core rel e69", rst_core, 1'b0);
    wait_rel(73); check("s2 video rel e73", rst_video, 1'b0);

    // One-cycle lock drop while counting at cnt==10.
    do_reset();
    wait_rel(13); locked = 1'b0;
    wait_rel(14); locked = 1'b1;
    wait_rel(19); check("s4 core held e19", rst_core, 1'b1);
    wait_rel(32); check("s4 core held e32", rst_core, 1'b1);
    wait_rel(33); check("s4 core rel e33", rst_core, 1'b0);
    wait_rel(37); check("s4 video rel e37", rst_video, 1'b0);
                  check("s4 ready e37", ready, 1'b1);

    // rst asserted while in CORE: full restart.
    do_reset();
    wait_rel(20); check("s5 in core rst_core", rst_core, 1'b0);
                  check("s5 in core rst_video", rst_video, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s5 rst core", rst_core, 1'b1);
    check("s5 rst video", rst_video, 1'b1);
    check("s5 rst ready", ready, 1'b0);
    wait_rel(18); check("s5 core held e18", rst_core, 1'b1);
    wait_rel(19); check("s5 core rel e19", rst_core, 1'b0);
    wait_rel(23); check("s5 video rel e23", rst_video, 1'b0);
                  check("s5 ready e23", ready, 1'b1);
    wait_rel(24); check("s5 ready gone", ready, 1'b0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
